// File: rtl/matrix_mult_sdiv_55s_24ns_seq.sv
// Sequential radix-2 restoring divider: signed DW-bit dividend by unsigned VW-bit divisor.
// Truncating (C-style) quotient and remainder; one operation in flight, DW+1 cycle latency.
module matrix_mult_sdiv_55s_24ns_seq #(
  parameter int unsigned DIVIDEND_WIDTH = 55,
  parameter int unsigned DIVISOR_WIDTH  = 24,
  parameter int unsigned ID             = 1
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DIVIDEND_WIDTH-1:0]  dividend,
  input  logic [DIVISOR_WIDTH-1:0]   divisor,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DIVIDEND_WIDTH-1:0]  quotient,
  output logic [DIVISOR_WIDTH:0]     remainder,
  output logic                       div_by_zero
);

  localparam int unsigned DW = DIVIDEND_WIDTH;
  localparam int unsigned VW = DIVISOR_WIDTH;
  localparam int unsigned CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            sign;
  logic [DW-1:0]   mag;    // dividend magnitude shifting out, quotient bits shifting in
  logic [VW-1:0]   dsr;
  logic [VW:0]     part;

  logic [VW+1:0]   shifted;
  logic [VW+1:0]   diff;
  logic            ge;
  logic            dz;

  logic unused_id;
  assign unused_id = ^ID;

  always_comb begin
    shifted = {part, mag[DW-1]};
    diff    = shifted - {2'b00, dsr};
    ge      = shifted >= {2'b00, dsr};
    dz      = (dsr == '0);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      sign        <= 1'b0;
      mag         <= '0;
      dsr         <= '0;
      part        <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sign     <= dividend[DW-1];
            // Negating -2^(DW-1) yields 2^(DW-1) when read as unsigned.
            mag      <= dividend[DW-1] ? (~dividend + 1'b1) : dividend;
            dsr      <= divisor;
            part     <= '0;
            cnt      <= CW'(DW - 1);
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (ge) begin
            part <= diff[VW:0];
          end else begin
            part <= shifted[VW:0];
          end
          mag <= {mag[DW-2:0], ge};
          if (cnt == '0) begin
            state <= FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        FIX: begin
          if (dz) begin
            quotient <= '1;
          end else begin
            quotient <= sign ? (~mag + 1'b1) : mag;
          end
          remainder   <= sign ? (~part + 1'b1) : part;
          div_by_zero <= dz;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mult_sdiv_55s_24ns_seq.sv
// Directed bench for the sequential signed divider: arithmetic vectors, latency,
// backpressure, and reset abort mid-operation.
module tb_matrix_mult_sdiv_55s_24ns_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        in_valid;
  logic        in_ready;
  logic [54:0] dividend;
  logic [23:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [54:0] quotient;
  logic [24:0] remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ap_clk = ~ap_clk;

  matrix_mult_sdiv_55s_24ns_seq dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] q64();
    return 64'($signed(quotient));
  endfunction

  function automatic logic [63:0] r64();
    return 64'($signed(remainder));
  endfunction

  // Issue one operation, scramble operands after acceptance, wait for the result.
  task automatic start_and_wait(input string tag, input logic [54:0] a, input logic [23:0] b,
                                output int cyc);
    @(negedge ap_clk);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    check({tag, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    dividend = 55'h2A_5A5A_5A5A_5A5A;
    divisor  = 24'h3C3C3C;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      @(posedge ap_clk);
      #1;
      cyc++;
    end
  endtask

  task automatic drain(input string tag);
    @(negedge ap_clk);
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    check({tag, " drain valid"}, 64'(out_valid), 64'd0);
    check({tag, " drain ready"}, 64'(in_ready), 64'd1);
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [54:0] a, input logic [23:0] b,
                        input logic [63:0] eq, input logic [63:0] er, input logic edz);
    int cyc;
    start_and_wait(tag, a, b, cyc);
    check({tag, " latency"}, 64'(cyc), 64'd56);
    check({tag, " quot"}, q64(), eq);
    check({tag, " rem"}, r64(), er);
    check({tag, " dz"}, 64'(div_by_zero), 64'(edz));
    drain(tag);
  endtask

  initial begin
    logic [63:0] neg_big;
    logic [63:0] hq;
    logic [63:0] hr;
    int          cyc;

    ap_rst    = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst quot", q64(), 64'd0);
    check("rst rem", r64(), 64'd0);
    check("rst dz", 64'(div_by_zero), 64'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;

    run_op("pos", 55'd1000, 24'd7, 64'd142, 64'd6, 1'b0);
    run_op("neg", -55'sd1000, 24'd7, -64'sd142, -64'sd6, 1'b0);
    neg_big = -(64'sd1 <<< 54);
    run_op("minint", {1'b1, 54'd0}, 24'd1, neg_big, 64'd0, 1'b0);
    run_op("maxmax", {1'b0, {54{1'b1}}}, 24'hFFFFFF, 64'd1073741888, 64'd63, 1'b0);
    run_op("divzero", 55'd12345, 24'd0, -64'sd1, 64'd12345, 1'b0 | 1'b1);

    // out_ready raised early has no effect on latency or result.
    @(negedge ap_clk);
    out_ready = 1'b1;
    start_and_wait("early", -55'sd77, 24'd5, cyc);
    check("early latency", 64'(cyc), 64'd56);
    check("early quot", q64(), -64'sd15);
    check("early rem", r64(), -64'sd2);
    @(posedge ap_clk);
    #1;
    check("early consumed", 64'(out_valid), 64'd0);
    out_ready = 1'b0;

    // Backpressure: result held for 20 cycles while in_valid pulses are ignored.
    start_and_wait("bp", 55'd1000, 24'd7, cyc);
    check("bp latency", 64'(cyc), 64'd56);
    hq = q64();
    hr = r64();
    check("bp quot", hq, 64'd142);
    check("bp rem", hr, 64'd6);
    for (int i = 0; i < 20; i++) begin
      @(negedge ap_clk);
      in_valid = i[0];
      dividend = 55'(i * 31 + 5);
      divisor  = 24'(i + 2);
      @(posedge ap_clk);
      #1;
      check("bp hold valid", 64'(out_valid), 64'd1);
      check("bp hold ready", 64'(in_ready), 64'd0);
      check("bp hold quot", q64(), 64'd142);
      check("bp hold rem", r64(), 64'd6);
    end
    @(negedge ap_clk);
    in_valid = 1'b0;
    drain("bp");
    @(posedge ap_clk);
    #1;
    check("bp idle stays", 64'(in_ready), 64'd1);

    // Reset 30 cycles into RUN aborts the operation.
    @(negedge ap_clk);
    dividend = 55'd5000;
    divisor  = 24'd3;
    in_valid = 1'b1;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    repeat (30) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst = 1'b1;
    @(posedge ap_clk);
    #1;
    check("abort out_valid", 64'(out_valid), 64'd0);
    check("abort in_ready", 64'(in_ready), 64'd1);
    check("abort quot", q64(), 64'd0);
    check("abort rem", r64(), 64'd0);
    check("abort dz", 64'(div_by_zero), 64'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    run_op("after rst", 55'd100, 24'd10, 64'd10, 64'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
